// File: rtl/whac_game_ctrl_pkg.sv
// Shared encodings, touch rectangles and helpers for the whac-a-mole controller.
package whac_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
    } rect_t;

    // Buttons sit above the hole grid (y < GRID_Y0) so they never alias a hole.
    localparam rect_t START_RECT   = '{x0: 16'd100, y0: 16'd20, x1: 16'd299, y1: 16'd99};
    localparam rect_t RESTART_RECT = '{x0: 16'd400, y0: 16'd20, x1: 16'd599, y1: 16'd99};
    localparam rect_t PAUSE_RECT   = '{x0: 16'd700, y0: 16'd0,  x1: 16'd799, y1: 16'd99};

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic in_rect(input rect_t r, input logic [15:0] x, input logic [15:0] y);
        return (x >= r.x0) && (x <= r.x1) && (y >= r.y0) && (y <= r.y1);
    endfunction

    // Maximal-length x^16+x^14+x^13+x^11+1 Fibonacci LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [31:0] sched_val(input logic [31:0] base, input logic [31:0] step,
                                              input logic [31:0] floor_v, input logic [3:0] lvl);
        logic [31:0] dec;
        dec = 32'(lvl - 4'd1) * step;
        if (dec >= base || (base - dec) < floor_v) return floor_v;
        return base - dec;
    endfunction

endpackage

// File: rtl/whac_game_ctrl_mole_slot.sv
// One hole: holds the lit flag and its own life countdown.
module whac_mole_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] life,
    input  logic        clear,
    input  logic        freeze,
    output logic        lit,
    output logic        expire_pulse
);
    logic [31:0] timer;

    // A clear in the same cycle (hit or game reset) suppresses the expiry.
    assign expire_pulse = lit && !freeze && !clear && (timer == 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            lit   <= 1'b0;
            timer <= '0;
        end else if (load) begin
            lit   <= 1'b1;
            timer <= life;
        end else if (lit && !freeze) begin
            timer <= timer - 32'd1;
            if (timer == 32'd1) lit <= 1'b0;
        end
    end

endmodule

// File: rtl/whac_game_ctrl.sv
// Whac-a-mole game controller: menu/play/pause/over FSM, hit decode, spawner, stats and levels.
module whac_game_ctrl
    import whac_game_ctrl_pkg::*;
#(
    parameter int          GRID_COLS     = 5,
    parameter int          GRID_ROWS     = 4,
    parameter logic [15:0] GRID_X0       = 16'd80,
    parameter logic [15:0] GRID_Y0       = 16'd120,
    parameter int          CELL_W_LOG2   = 7,
    parameter int          CELL_H_LOG2   = 7,
    parameter int          LEVELS        = 8,
    parameter int          KILLS_PER_LVL = 10,
    parameter int          MAX_RUNAWAY   = 10,
    parameter int          COMBO_THRESH  = 3,
    parameter logic [31:0] BASE_LIFE     = 32'd50_000_000,
    parameter logic [31:0] LIFE_STEP     = 32'd5_000_000,
    parameter logic [31:0] MIN_LIFE      = 32'd10_000_000,
    parameter logic [31:0] BASE_GEN      = 32'd40_000_000,
    parameter logic [31:0] GEN_STEP      = 32'd4_000_000,
    parameter logic [31:0] MIN_GEN       = 32'd8_000_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           move_on,
    input  logic [15:0]                    tp_x_coord,
    input  logic [15:0]                    tp_y_coord,
    output logic [1:0]                     state,
    output logic [GRID_COLS*GRID_ROWS-1:0] moles,
    output logic [31:0]                    life_span,
    output logic [31:0]                    gen_interval,
    output logic [9:0]                     score,
    output logic [7:0]                     kill,
    output logic [7:0]                     runaway,
    output logic [7:0]                     combo,
    output logic [3:0]                     level
);
    localparam int NUM_HOLES = GRID_COLS * GRID_ROWS;

    game_state_e          state_q, state_d;
    logic                 move_on_q, tev, active, enter_play, clear_all;
    logic                 in_grid, spawn, any_hit, any_exp, miss, lvl_up;
    logic [15:0]          dx, dy, col, row, lfsr, tgt;
    logic [31:0]          spawn_cnt;
    logic [NUM_HOLES-1:0] lit, hit_vec, load_vec, exp_vec;
    logic [7:0]           exp_cnt, kill_inc;
    logic [8:0]           run_sum;
    logic [10:0]          score_sum;
    logic [3:0]           level_inc;

    assign tev    = move_on && !move_on_q;
    // Game time only advances while playing and not yet over the runaway limit.
    assign active = (state_q == ST_PLAY) && (runaway < 8'(MAX_RUNAWAY));
    assign state  = state_q;
    assign moles  = lit;

    assign dx      = tp_x_coord - GRID_X0;
    assign dy      = tp_y_coord - GRID_Y0;
    assign col     = dx >> CELL_W_LOG2;
    assign row     = dy >> CELL_H_LOG2;
    assign in_grid = (tp_x_coord >= GRID_X0) && (tp_y_coord >= GRID_Y0) &&
                     (col < 16'(GRID_COLS)) && (row < 16'(GRID_ROWS));

    assign tgt       = lfsr % 16'(NUM_HOLES);
    assign spawn     = active && (spawn_cnt >= gen_interval - 32'd1);
    assign clear_all = enter_play || (state_q == ST_PLAY && !active);
    assign any_hit   = |hit_vec;
    assign any_exp   = |exp_vec;
    assign miss      = active && tev && in_grid && !any_hit;

    for (genvar i = 0; i < NUM_HOLES; i++) begin : g_slot
        assign hit_vec[i]  = active && tev && in_grid && lit[i] &&
                             (col == 16'(i % GRID_COLS)) && (row == 16'(i / GRID_COLS));
        // A lit target (which also covers a hole being hit) skips this spawn.
        assign load_vec[i] = spawn && (tgt == 16'(i)) && !lit[i];
        whac_mole_slot u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .load         (load_vec[i]),
            .life         (life_span),
            .clear        (clear_all || hit_vec[i]),
            .freeze       (!active),
            .lit          (lit[i]),
            .expire_pulse (exp_vec[i])
        );
    end

    always_comb begin
        exp_cnt = '0;
        for (int i = 0; i < NUM_HOLES; i++) exp_cnt = exp_cnt + 8'(exp_vec[i]);
    end

    always_comb begin
        state_d    = state_q;
        enter_play = 1'b0;
        case (state_q)
            ST_MENU:
                if (tev && in_rect(START_RECT, tp_x_coord, tp_y_coord)) begin
                    state_d    = ST_PLAY;
                    enter_play = 1'b1;
                end
            ST_PLAY:
                if (!active) state_d = ST_OVER;
                else if (tev && in_rect(PAUSE_RECT, tp_x_coord, tp_y_coord)) state_d = ST_PAUSE;
            ST_PAUSE:
                if (tev && in_rect(PAUSE_RECT, tp_x_coord, tp_y_coord)) state_d = ST_PLAY;
            ST_OVER:
                if (tev && in_rect(RESTART_RECT, tp_x_coord, tp_y_coord)) begin
                    state_d    = ST_PLAY;
                    enter_play = 1'b1;
                end else if (tev && in_rect(START_RECT, tp_x_coord, tp_y_coord)) begin
                    state_d = ST_MENU;
                end
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_MENU;
            move_on_q <= 1'b0;
            lfsr      <= LFSR_SEED;
            spawn_cnt <= '0;
        end else begin
            state_q   <= state_d;
            move_on_q <= move_on;
            if (enter_play) begin
                spawn_cnt <= '0;
            end else if (spawn) begin
                spawn_cnt <= '0;
                lfsr      <= lfsr_step(lfsr);
            end else if (active) begin
                spawn_cnt <= spawn_cnt + 32'd1;
            end
        end
    end

    // Combo is judged on its value before this hit is counted.
    assign score_sum = {1'b0, score} + ((combo >= 8'(COMBO_THRESH)) ? 11'd2 : 11'd1);
    assign kill_inc  = (kill == 8'hFF) ? kill : kill + 8'd1;
    assign level_inc = level + 4'd1;
    assign lvl_up    = any_hit && (kill_inc % 8'(KILLS_PER_LVL) == 8'd0) && (level < 4'(LEVELS));
    assign run_sum   = {1'b0, runaway} + {1'b0, exp_cnt};

    always_ff @(posedge clk) begin
        if (!rst_n || enter_play) begin
            score        <= '0;
            kill         <= '0;
            runaway      <= '0;
            combo        <= '0;
            level        <= 4'd1;
            life_span    <= BASE_LIFE;
            gen_interval <= BASE_GEN;
        end else if (active) begin
            if (any_hit) begin
                score <= (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
                kill  <= kill_inc;
            end
            if (lvl_up) begin
                level        <= level_inc;
                life_span    <= sched_val(BASE_LIFE, LIFE_STEP, MIN_LIFE, level_inc);
                gen_interval <= sched_val(BASE_GEN, GEN_STEP, MIN_GEN, level_inc);
            end
            runaway <= run_sum[8] ? 8'hFF : run_sum[7:0];
            // An escape breaks the streak even if another hole is hit that cycle.
            if (any_exp || miss) combo <= '0;
            else if (any_hit && combo != 8'hFF) combo <= combo + 8'd1;
        end
    end

endmodule
